// File: rtl/line_buffer_feeder_pkg.sv
// rtl/line_buffer_feeder_pkg.sv - shared sizes, state encoding and width helper for the line buffer feeder
package line_buffer_feeder_pkg;

    localparam int kNoOfPartitions     = 4;
    localparam int kPartitionSize      = 8;
    localparam int kFilteredDataLength = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FILL  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Bits needed to hold the value itself, not just value-1.
    function automatic int bin_width(input int value);
        return $clog2(value + 1);
    endfunction

endpackage

// File: rtl/line_buffer_feeder.sv
// rtl/line_buffer_feeder.sv - write-side controller loading one filtered projection line into the line buffer
module line_buffer_feeder
    import line_buffer_feeder_pkg::*;
#(
    parameter int pNoTaps      = kNoOfPartitions,
    parameter int pTapsWidth   = kPartitionSize,
    parameter int pDataLength  = kFilteredDataLength,
    parameter int pLineLength  = pNoTaps * pTapsWidth,
    parameter int pCountLength = bin_width(pLineLength)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [pDataLength-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [pDataLength-1:0]  lb_shift_in,
    output logic                    lb_enable,
    output logic                    lb_clear,
    output logic                    line_ready,
    input  logic                    line_ack,
    output logic                    busy,
    output logic                    overrun,
    output logic [pCountLength-1:0] shift_count
);

    localparam logic [pCountLength-1:0] kLineLen = pCountLength'(pLineLength);

    state_e                  state_q, state_d;
    logic [pCountLength-1:0] count_q, count_d;
    logic [pDataLength-1:0]  shift_q, shift_d;
    logic                    enable_q, enable_d;
    logic                    clear_q, clear_d;
    logic                    ready_q, ready_d;
    logic                    overrun_q, overrun_d;
    logic [pCountLength-1:0] count_inc;
    logic                    line_full;
    logic                    handshake;

    // Saturating increment keeps shift_count from ever wrapping past the line length.
    assign count_inc = (count_q == kLineLen) ? count_q : count_q + 1'b1;
    assign line_full = (count_inc == kLineLen);
    assign in_ready  = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign handshake = in_valid & in_ready;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        enable_d  = 1'b0;
        clear_d   = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    clear_d   = 1'b1;
                    count_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_CLEAR: state_d = ST_FILL;
            ST_FILL: begin
                if (handshake) begin
                    enable_d = 1'b1;
                    shift_d  = in_data;
                    count_d  = count_inc;
                    if (line_full) begin
                        if (in_last) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_DRAIN;
                            overrun_d = 1'b1;
                        end
                    end else if (in_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                enable_d = 1'b1;
                shift_d  = '0;
                count_d  = count_inc;
                if (line_full) state_d = ST_DONE;
            end
            ST_DRAIN: begin
                if (handshake && in_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (line_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            enable_q  <= 1'b0;
            clear_q   <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            enable_q  <= enable_d;
            clear_q   <= clear_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign lb_shift_in = shift_q;
    assign lb_enable   = enable_q;
    assign lb_clear    = clear_q;
    assign line_ready  = ready_q;
    assign overrun     = overrun_q;
    assign shift_count = count_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// tb/tb_line_buffer_feeder.sv - scoreboard bench for line_buffer_feeder with a behavioural line buffer
module tb_line_buffer_feeder;
    import line_buffer_feeder_pkg::*;

    localparam int NT = 4;
    localparam int TW = 8;
    localparam int DW = 16;
    localparam int L  = NT * TW;
    localparam int CW = 6;

    localparam int M_SEQ    = 1;
    localparam int M_BUBBLE = 2;
    localparam int M_RAND   = 4;
    localparam int M_POKE   = 8;
    localparam int M_ACKST  = 16;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] lb_shift_in;
    logic          lb_enable;
    logic          lb_clear;
    logic          line_ready;
    logic          line_ack;
    logic          busy;
    logic          overrun;
    logic [CW-1:0] shift_count;

    line_buffer_feeder #(
        .pNoTaps    (NT),
        .pTapsWidth (TW),
        .pDataLength(DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .lb_shift_in(lb_shift_in),
        .lb_enable  (lb_enable),
        .lb_clear   (lb_clear),
        .line_ready (line_ready),
        .line_ack   (line_ack),
        .busy       (busy),
        .overrun    (overrun),
        .shift_count(shift_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] lb_model[L];
    logic [DW-1:0] stream[L];
    int            en_cnt, clr_cnt, acc;
    bit            hs_prev;
    logic [DW-1:0] last_shift;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: models the line buffer and pops the scoreboard on every enable.
    initial begin
        hs_prev = 0; last_shift = '0; en_cnt = 0; clr_cnt = 0; acc = 0;
        for (int k = 0; k < L; k++) lb_model[k] = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hs_prev = 0; last_shift = '0; acc = 0;
            end else begin
                if (lb_clear) begin
                    clr_cnt++; en_cnt = 0; acc = 0;
                    for (int k = 0; k < L; k++) lb_model[k] = '0;
                end
                if (hs_prev) chk("enable_latency", lb_enable, 1);
                if (lb_enable) begin
                    en_cnt++;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_enable: got shift_in %0h with empty scoreboard at %0t", lb_shift_in, $time);
                    end else begin
                        chk("shift_data", lb_shift_in, exp_q.pop_front());
                    end
                    for (int k = L - 1; k > 0; k--) lb_model[k] = lb_model[k-1];
                    lb_model[0] = lb_shift_in;
                end else begin
                    chk("shift_hold", lb_shift_in, last_shift);
                end
                last_shift = lb_shift_in;
                hs_prev = in_valid && in_ready && (acc < L);
                if (in_valid && in_ready) acc++;
            end
        end
    end

    task automatic send_sample(input logic [DW-1:0] d, input bit last, input bit poke);
        int w;
        in_valid = 1'b1; in_data = d; in_last = last;
        if (poke) begin start = 1'b1; line_ack = 1'b1; end
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 8) begin @(negedge clk); w++; end
        chk("in_ready", in_ready, 1);
        @(posedge clk); #1;
        start = 1'b0; line_ack = 1'b0;
    endtask

    task automatic begin_line(input int n, input int mode, output logic [DW-1:0] data[$]);
        data.delete();
        for (int i = 0; i < n; i++) data.push_back((mode & M_SEQ) ? DW'(i + 1) : DW'($urandom));
        for (int i = 0; i < L; i++) begin
            stream[i] = (i < n) ? data[i] : '0;
            exp_q.push_back(stream[i]);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("clear_pulse", lb_clear, 1);
        chk("busy_run", busy, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_line(input int n, input int mode);
        logic [DW-1:0] data[$];
        int clr0, w;
        clr0 = clr_cnt;
        begin_line(n, mode, data);
        for (int i = 0; i < n; i++) begin
            if (((mode & M_BUBBLE) && (i % 2 == 1)) || ((mode & M_RAND) && ($urandom_range(0, 3) == 0))) begin
                in_valid = 1'b0; in_last = $urandom_range(0, 1);
                repeat (2) @(posedge clk);
                #1;
            end
            send_sample(data[i], i == n - 1, ((mode & M_POKE) != 0) && i == 5);
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("ready_after_last", in_ready, 0);
        w = 0;
        while (!line_ready && w < 100) begin @(negedge clk); w++; end
        chk("line_ready", line_ready, 1);
        @(posedge clk); #1;
        chk("enable_total", en_cnt, L);
        chk("shift_count", shift_count, L);
        chk("overrun", overrun, (n > L) ? 1 : 0);
        chk("done_enable_low", lb_enable, 0);
        chk("clear_once", clr_cnt, clr0 + 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        for (int k = 0; k < NT; k++) chk($sformatf("tap%0d", k), lb_model[k*TW], stream[L-1-k*TW]);
        line_ack = 1'b1;
        if (mode & M_ACKST) start = 1'b1;
        @(posedge clk); #1;
        line_ack = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("ready_dropped", line_ready, 0);
        chk("busy_idle", busy, 0);
        chk("no_clear_on_ack", clr_cnt, clr0 + 1);
        exp_q.delete();
    endtask

    task automatic reset_mid_line();
        logic [DW-1:0] data[$];
        begin_line(L, M_RAND, data);
        for (int i = 0; i < 10; i++) send_sample(data[i], 1'b0, 1'b0);
        chk("count_before_reset", shift_count, 10);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_enable", lb_enable, 0);
        chk("rst_clear", lb_clear, 0);
        chk("rst_shift_in", lb_shift_in, 0);
        chk("rst_line_ready", line_ready, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_count", shift_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; line_ack = 1'b0;
        #12;
        chk("reset_enable", lb_enable, 0);
        chk("reset_clear", lb_clear, 0);
        chk("reset_line_ready", line_ready, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_count", shift_count, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        run_line(L, M_SEQ);
        run_line(20, 0);
        run_line(40, 0);
        run_line(L, M_BUBBLE);
        run_line(25, M_POKE | M_ACKST);
        run_line(L - 1, M_RAND);
        run_line(1, 0);
        reset_mid_line();
        run_line(L, 0);
        for (int r = 0; r < 6; r++) run_line($urandom_range(1, 45), M_RAND);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
